skid_fifo_buffer: RTL and testbench
===================================

# skid_fifo_buffer

Parametrised successor to the two-entry skid buffer: a DEPTH-entry elastic buffer between a producer (i_*) and a consumer (e_*) using valid/ready handshakes. Unlike the fixed 8-bit, two-slot version, it has configurable width and depth, a registered i_ready_o that breaks the ready path, an optional empty-bypass mode, occupancy/almost-full status, and a synchronous flush. It sits on any stream boundary where e_ready_i timing must not reach the producer combinationally.

## Interface
- DATA_W, 8: payload width in bits, ≥1.
- DEPTH, 4: storage entries; a power of two, ≥2.
- BYPASS, 0: 1 = when empty, input passes to output in the same cycle; 0 = output always from storage.
- AF_THRESH, DEPTH-1: almost_full_o asserts when level ≥ AF_THRESH; range 1..DEPTH.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0); release is synchronised externally.
- flush  in  1  synchronous clear of all stored entries.
- i_valid_i  in  1  producer data valid.
- i_data_i  in  DATA_W  producer payload.
- i_ready_o  out  1  buffer can accept; driven directly from a flop.
- e_ready_i  in  1  consumer ready.
- e_valid_o  out  1  output payload valid.
- e_data_o  out  DATA_W  output payload.
- level_o  out  $clog2(DEPTH+1)  number of stored entries.
- almost_full_o  out  1  level_o ≥ AF_THRESH, registered.

## Operation
- Input transfer: i_valid_i && i_ready_o at a rising edge. Output transfer: e_valid_o && e_ready_i.
- Storage is a circular array with wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap naturally; level is a separate counter.
- Next level = level + in_xfer − out_xfer_from_storage. When both occur, the level is unchanged and the pointers advance.
- i_ready_o register <= (next level < DEPTH) && !flush. Because it uses the next level, full is exact: a full buffer drained in cycle N accepts in cycle N+1.
- BYPASS=0: e_valid_o = (level != 0); e_data_o = mem[rd_ptr].
- BYPASS=1, level==0: e_valid_o = i_valid_i && i_ready_o; e_data_o = i_data_i. If e_ready_i is also high, the word is consumed without being written. Otherwise it is written and level becomes 1.
- BYPASS=1, level>0: behaves as BYPASS=0. Ordering is preserved, and bypass never overtakes stored data.
- Flush, when high at an edge:
  - Sets level, wr_ptr and rd_ptr to 0.
  - Discards any input transfer in that cycle.
  - An output transfer in that cycle counts as delivered.
  - Sets i_ready_o to 0 for the next cycle.
- Reset, asserted at any time (including mid-operation):
  - Immediately sets level, pointers, i_ready_o, almost_full_o and all storage to 0.
  - Resulting outputs: e_valid_o=0, e_data_o=0, level_o=0.
  - In-flight data is lost.

## Timing
- Latency with BYPASS=0: a word accepted at edge N appears on e_data_o after edge N, with e_valid_o high in cycle N+1.
- Latency with BYPASS=1 and empty: 0 cycles (combinational input-to-output).
- i_ready_o rises on the first clk edge after reset deasserts. It has no combinational dependence on e_ready_i or i_valid_i.
- Throughput: one transfer per cycle sustained in both directions at any level.
- level_o and almost_full_o update one edge after the causing transfer.

## Structure
- Shared package skid_pkg holds:
  - the BYPASS_OFF/BYPASS_ON localparams;
  - a level-width helper function;
  - elaboration checks (DEPTH power of two ≥2, AF_THRESH in range).
- One natural sub-module, skid_fifo_ctrl, holds pointers, level counter, ready and almost-full registers. The storage array and output muxing stay in the top module.

## Test plan
- Reset then stream, DATA_W=8, DEPTH=4, BYPASS=0, e_ready_i=1, inputs 0x01..0x10 back-to-back.
  - Required: outputs 0x01..0x10 in order, one per cycle, first output one cycle after acceptance, level_o stays 1.
- Fill with e_ready_i=0, inputs 0xA0..0xA5.
  - Required: 0xA0..0xA3 accepted, i_ready_o=0 from the cycle after the 4th accept, level_o=4, almost_full_o=1 once level_o reaches 3.
  - Then raise e_ready_i for one cycle: i_ready_o=1 on the next cycle and 0xA4 is accepted.
- BYPASS=1, empty, e_ready_i=1, i_data_i=0x5A.
  - Required: e_data_o=0x5A and e_valid_o=1 in the same cycle, level_o stays 0.
  - Then repeat with e_ready_i=0: 0x5A is stored, level_o=1.
- Flush with 3 entries stored and i_valid_i=1 (data 0x77) in the flush cycle.
  - Required: next cycle level_o=0, e_valid_o=0, i_ready_o=0, and 0x77 never appears at the output.
- Reset asserted mid-stream at level_o=2.
  - Required: e_valid_o, i_ready_o, level_o and e_data_o are 0 immediately without waiting for a clock edge.
  - After release, a fresh stream 0x10, 0x11 emerges with no stale data.
- Random valid/ready, DEPTH=8, 10k cycles, scoreboard.
  - Required: no loss, duplication or reordering; i_ready_o never high while level_o=8.

Source files
------------

// File: rtl/skid_fifo_buffer_pkg.sv
// ---------------------------------------------------------------------------
// skid_pkg
// Shared definitions for the skid FIFO buffer slice.
//   BYPASS_OFF / BYPASS_ON : values for the BYPASS parameter of skid_fifo_buffer
//   level_width()          : width of an occupancy counter able to hold 0..DEPTH
//   depth_ok()             : legality check for the DEPTH parameter
//   af_thresh_ok()         : legality check for the AF_THRESH parameter
// ---------------------------------------------------------------------------
package skid_pkg;

    localparam bit BYPASS_OFF = 1'b0;
    localparam bit BYPASS_ON  = 1'b1;

    // A counter of 0..depth inclusive needs one more code point than a pointer.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointers wrap naturally, so the depth has to be a power of two.
    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit af_thresh_ok(input int thresh, input int depth);
        return (thresh >= 1) && (thresh <= depth);
    endfunction

endpackage

// File: rtl/skid_fifo_buffer_if.sv
// ---------------------------------------------------------------------------
// skid_fifo_buffer_if
// Producer and consumer valid/ready handshakes of the skid FIFO buffer.
//   i_valid_i / i_data_i / i_ready_o : producer side (into the buffer)
//   e_valid_o / e_data_o / e_ready_i : consumer side (out of the buffer)
// Modports:
//   slave  : the buffer itself
//   master : the environment driving and draining the buffer
// ---------------------------------------------------------------------------
interface skid_fifo_buffer_if #(
    parameter int DATA_W = 8
);

    logic              i_valid_i;
    logic [DATA_W-1:0] i_data_i;
    logic              i_ready_o;
    logic              e_valid_o;
    logic [DATA_W-1:0] e_data_o;
    logic              e_ready_i;

    modport slave (
        input  i_valid_i, i_data_i, e_ready_i,
        output i_ready_o, e_valid_o, e_data_o
    );

    modport master (
        output i_valid_i, i_data_i, e_ready_i,
        input  i_ready_o, e_valid_o, e_data_o
    );

endinterface

// File: rtl/skid_fifo_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// skid_fifo_ctrl
// Pointer / occupancy bookkeeping for skid_fifo_buffer.
//   clk, reset     : clock, asynchronous active-low reset
//   flush          : synchronous clear of pointers and level
//   push, pop      : write into / read out of the storage array this cycle
//   wr_ptr_o       : storage slot written by the next push
//   rd_ptr_o       : storage slot at the head of the queue
//   level_o        : number of stored entries
//   ready_o        : registered "can accept" for the producer
//   almost_full_o  : registered level_o >= AF_THRESH
// ---------------------------------------------------------------------------
module skid_fifo_ctrl
    import skid_pkg::*;
#(
    parameter  int DEPTH     = 4,
    parameter  int AF_THRESH = DEPTH - 1,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int LVL_W     = level_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [LVL_W-1:0] level_o,
    output logic             ready_o,
    output logic             almost_full_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ready_q, ready_d;
    logic             almost_full_q, almost_full_d;

    // Ready and almost-full are derived from the *next* level so that a slot
    // freed by a pop this cycle is offered to the producer on the very next
    // cycle, while the producer still only ever sees a flop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        end
        ready_d       = (level_d < LVL_W'(DEPTH)) && !flush;
        almost_full_d = (level_d >= LVL_W'(AF_THRESH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            ready_q       <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            ready_q       <= ready_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign wr_ptr_o      = wr_ptr_q;
    assign rd_ptr_o      = rd_ptr_q;
    assign level_o       = level_q;
    assign ready_o       = ready_q;
    assign almost_full_o = almost_full_q;

endmodule

// File: rtl/skid_fifo_buffer.sv
// ---------------------------------------------------------------------------
// skid_fifo_buffer
// DEPTH-entry elastic buffer between a producer and a consumer using
// valid/ready handshakes. i_ready_o comes straight from a flop, so consumer
// ready timing never reaches the producer combinationally. With BYPASS set,
// an empty buffer forwards input to output in the same cycle.
//   clk, reset      : clock, asynchronous active-low reset
//   flush           : synchronous clear of all stored entries
//   bus (slave)     : i_valid_i/i_data_i/i_ready_o and e_valid_o/e_data_o/e_ready_i
//   level_o         : number of stored entries
//   almost_full_o   : registered level_o >= AF_THRESH
// ---------------------------------------------------------------------------
module skid_fifo_buffer
    import skid_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 4,
    parameter  bit BYPASS    = BYPASS_OFF,
    parameter  int AF_THRESH = DEPTH - 1,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int LVL_W     = level_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    skid_fifo_buffer_if.slave     bus,
    output logic [LVL_W-1:0]      level_o,
    output logic                  almost_full_o
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("skid_fifo_buffer: DEPTH must be a power of two >= 2");
    end
    if (!af_thresh_ok(AF_THRESH, DEPTH)) begin : g_bad_af_thresh
        $error("skid_fifo_buffer: AF_THRESH must lie in 1..DEPTH");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             i_ready;
    logic             storage_empty;
    logic             bypass_active;
    logic             in_xfer;
    logic             bypass_taken;
    logic             push;
    logic             pop;
    logic             e_valid;
    logic [DATA_W-1:0] e_data;

    skid_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
    ) u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .push          (push),
        .pop           (pop),
        .wr_ptr_o      (wr_ptr),
        .rd_ptr_o      (rd_ptr),
        .level_o       (level),
        .ready_o       (i_ready),
        .almost_full_o (almost_full_o)
    );

    // Bypass only ever applies to an empty store, so it can never overtake
    // data that is already queued. A bypassed word that the consumer takes in
    // the same cycle is never written; otherwise it lands in storage as usual.
    always_comb begin
        storage_empty = (level == '0);
        bypass_active = (BYPASS == BYPASS_ON) && storage_empty;
        in_xfer       = bus.i_valid_i && i_ready;
        bypass_taken  = bypass_active && in_xfer && bus.e_ready_i;
        push          = in_xfer && !bypass_taken && !flush;
        pop           = !storage_empty && bus.e_ready_i;
        e_valid       = bypass_active ? in_xfer : !storage_empty;
        e_data        = (bypass_active && in_xfer) ? bus.i_data_i : mem_q[rd_ptr];
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr] = bus.i_data_i;
        end
    end

    // Storage is cleared on reset so that e_data_o reads zero afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign bus.i_ready_o = i_ready;
    assign bus.e_valid_o = e_valid;
    assign bus.e_data_o  = e_data;
    assign level_o       = level;

endmodule

// File: tb/tb_skid_fifo_buffer.sv
// ---------------------------------------------------------------------------
// tb_skid_fifo_buffer
// Three buffer instances share clock and reset:
//   dut_a : DEPTH=4, BYPASS=0  (streaming, fill, flush, reset scenarios)
//   dut_b : DEPTH=4, BYPASS=1  (same-cycle bypass and ordering)
//   dut_c : DEPTH=8, BYPASS=1, AF_THRESH=6 (random traffic vs. queue model)
// ---------------------------------------------------------------------------
module tb_skid_fifo_buffer;
    import skid_pkg::*;

    logic clk;
    logic reset;
    logic flush_a, flush_b, flush_c;
    logic [2:0] level_a, level_b;
    logic [3:0] level_c;
    logic almost_full_a, almost_full_b, almost_full_c;

    int total;
    int bad;
    int acc;

    // random-test model state
    logic [7:0] q[$];
    logic       exp_ready_c;
    logic       rv, rr, rf;
    logic [7:0] rd;
    logic       bypass, in_x, out_x, exp_valid;
    logic [7:0] exp_data;
    int         rate_v, rate_r;

    skid_fifo_buffer_if #(.DATA_W(8)) if_a ();
    skid_fifo_buffer_if #(.DATA_W(8)) if_b ();
    skid_fifo_buffer_if #(.DATA_W(8)) if_c ();

    skid_fifo_buffer #(.DATA_W(8), .DEPTH(4), .BYPASS(BYPASS_OFF)) dut_a (
        .clk(clk), .reset(reset), .flush(flush_a), .bus(if_a),
        .level_o(level_a), .almost_full_o(almost_full_a)
    );

    skid_fifo_buffer #(.DATA_W(8), .DEPTH(4), .BYPASS(BYPASS_ON)) dut_b (
        .clk(clk), .reset(reset), .flush(flush_b), .bus(if_b),
        .level_o(level_b), .almost_full_o(almost_full_b)
    );

    skid_fifo_buffer #(.DATA_W(8), .DEPTH(8), .BYPASS(BYPASS_ON), .AF_THRESH(6)) dut_c (
        .clk(clk), .reset(reset), .flush(flush_c), .bus(if_c),
        .level_o(level_c), .almost_full_o(almost_full_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int which, input logic v, input logic [7:0] d, input logic r);
        case (which)
            0: begin if_a.i_valid_i = v; if_a.i_data_i = d; if_a.e_ready_i = r; end
            1: begin if_b.i_valid_i = v; if_b.i_data_i = d; if_b.e_ready_i = r; end
            default: begin if_c.i_valid_i = v; if_c.i_data_i = d; if_c.e_ready_i = r; end
        endcase
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        flush_a = 1'b0;
        flush_b = 1'b0;
        flush_c = 1'b0;
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1, 1'b0, 8'h00, 1'b0);
        applyStimulus(2, 1'b0, 8'h00, 1'b0);

        // reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_ready", if_a.i_ready_o, 1'b0);
        checkOutput("rst_valid", if_a.e_valid_o, 1'b0);
        checkOutput("rst_level", level_a, 0);
        checkOutput("rst_af", almost_full_a, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rel_ready", if_a.i_ready_o, 1'b1);

        // back-to-back stream 0x01..0x10 with consumer always ready
        $display("[TB] stream test");
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k < 16) applyStimulus(0, 1'b1, 8'(k + 1), 1'b1);
            else        applyStimulus(0, 1'b0, 8'h00, 1'b1);
            #1;
            checkOutput("stream_ready", if_a.i_ready_o, 1'b1);
            checkOutput("stream_level", level_a, (k == 0) ? 0 : 1);
            checkOutput("stream_valid", if_a.e_valid_o, (k == 0) ? 0 : 1);
            if (k > 0) checkOutput("stream_data", if_a.e_data_o, k);
        end
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        #1;
        checkOutput("stream_empty", level_a, 0);

        // fill with a stalled consumer, producer holds 0xA4 until accepted
        $display("[TB] fill test");
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            applyStimulus(0, 1'b1, 8'(8'hA0 + acc), 1'b0);
            #1;
            checkOutput("fill_level", level_a, (k < 4) ? k : 4);
            checkOutput("fill_ready", if_a.i_ready_o, (k < 4) ? 1 : 0);
            checkOutput("fill_af", almost_full_a, (k >= 3) ? 1 : 0);
            checkOutput("fill_valid", if_a.e_valid_o, (k >= 1) ? 1 : 0);
            if (k >= 1) checkOutput("fill_head", if_a.e_data_o, 8'hA0);
            if (k < 4) acc++;
        end
        @(negedge clk);
        applyStimulus(0, 1'b1, 8'hA4, 1'b1);
        #1;
        checkOutput("pop1_ready", if_a.i_ready_o, 1'b0);
        checkOutput("pop1_level", level_a, 4);
        @(negedge clk);
        applyStimulus(0, 1'b1, 8'hA4, 1'b0);
        #1;
        checkOutput("reopen_ready", if_a.i_ready_o, 1'b1);
        checkOutput("reopen_level", level_a, 3);
        checkOutput("reopen_head", if_a.e_data_o, 8'hA1);
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        #1;
        checkOutput("refill_level", level_a, 4);
        checkOutput("refill_ready", if_a.i_ready_o, 1'b0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            applyStimulus(0, 1'b0, 8'h00, 1'b1);
            #1;
            checkOutput("drain_valid", if_a.e_valid_o, 1'b1);
            checkOutput("drain_data", if_a.e_data_o, 8'hA1 + j);
        end
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        #1;
        checkOutput("drain_level", level_a, 0);
        checkOutput("drain_empty", if_a.e_valid_o, 1'b0);

        // bypass through an empty buffer
        $display("[TB] bypass test");
        @(negedge clk);
        applyStimulus(1, 1'b1, 8'h5A, 1'b1);
        #1;
        checkOutput("byp_valid", if_b.e_valid_o, 1'b1);
        checkOutput("byp_data", if_b.e_data_o, 8'h5A);
        checkOutput("byp_level", level_b, 0);
        @(negedge clk);
        applyStimulus(1, 1'b0, 8'h00, 1'b1);
        #1;
        checkOutput("byp_level_after", level_b, 0);
        checkOutput("byp_valid_after", if_b.e_valid_o, 1'b0);
        @(negedge clk);
        applyStimulus(1, 1'b1, 8'h5A, 1'b0);
        #1;
        checkOutput("byp_stall_valid", if_b.e_valid_o, 1'b1);
        checkOutput("byp_stall_data", if_b.e_data_o, 8'h5A);
        @(negedge clk);
        applyStimulus(1, 1'b1, 8'h66, 1'b1);
        #1;
        checkOutput("byp_stored_level", level_b, 1);
        checkOutput("byp_order_data", if_b.e_data_o, 8'h5A);
        @(negedge clk);
        applyStimulus(1, 1'b0, 8'h00, 1'b1);
        #1;
        checkOutput("byp_second_level", level_b, 1);
        checkOutput("byp_second_data", if_b.e_data_o, 8'h66);
        @(negedge clk);
        applyStimulus(1, 1'b0, 8'h00, 1'b0);
        #1;
        checkOutput("byp_final_level", level_b, 0);
        checkOutput("byp_final_valid", if_b.e_valid_o, 1'b0);

        // flush with three stored entries and a word offered in the same cycle
        $display("[TB] flush test");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            applyStimulus(0, 1'b1, 8'(8'hB0 + k), 1'b0);
        end
        @(negedge clk);
        flush_a = 1'b1;
        applyStimulus(0, 1'b1, 8'h77, 1'b0);
        #1;
        checkOutput("preflush_level", level_a, 3);
        checkOutput("preflush_af", almost_full_a, 1'b1);
        @(negedge clk);
        flush_a = 1'b0;
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        #1;
        checkOutput("flush_level", level_a, 0);
        checkOutput("flush_valid", if_a.e_valid_o, 1'b0);
        checkOutput("flush_ready", if_a.i_ready_o, 1'b0);
        checkOutput("flush_af", almost_full_a, 1'b0);
        @(negedge clk);
        applyStimulus(0, 1'b1, 8'h21, 1'b1);
        #1;
        checkOutput("postflush_ready", if_a.i_ready_o, 1'b1);
        checkOutput("postflush_valid", if_a.e_valid_o, 1'b0);
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'h00, 1'b1);
        #1;
        checkOutput("postflush_data", if_a.e_data_o, 8'h21);
        checkOutput("postflush_lvl", level_a, 1);
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        #1;
        checkOutput("postflush_empty", if_a.e_valid_o, 1'b0);

        // asynchronous reset with two entries stored
        $display("[TB] reset test");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            applyStimulus(0, 1'b1, 8'(8'hC0 + k), 1'b0);
        end
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        #1;
        checkOutput("prerst_level", level_a, 2);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_valid", if_a.e_valid_o, 1'b0);
        checkOutput("arst_ready", if_a.i_ready_o, 1'b0);
        checkOutput("arst_level", level_a, 0);
        checkOutput("arst_data", if_a.e_data_o, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rerel_ready", if_a.i_ready_o, 1'b1);
        checkOutput("rerel_valid", if_a.e_valid_o, 1'b0);
        @(negedge clk);
        applyStimulus(0, 1'b1, 8'h10, 1'b1);
        @(negedge clk);
        applyStimulus(0, 1'b1, 8'h11, 1'b1);
        #1;
        checkOutput("fresh0_valid", if_a.e_valid_o, 1'b1);
        checkOutput("fresh0_data", if_a.e_data_o, 8'h10);
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'h00, 1'b1);
        #1;
        checkOutput("fresh1_data", if_a.e_data_o, 8'h11);
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        #1;
        checkOutput("fresh_empty", if_a.e_valid_o, 1'b0);
        checkOutput("fresh_level", level_a, 0);

        // random traffic on the DEPTH=8 bypass instance against a queue model
        $display("[TB] random test");
        q.delete();
        exp_ready_c = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            rate_v = (((c / 1000) % 2) == 0) ? 70 : 40;
            rate_r = (((c / 1000) % 2) == 0) ? 30 : 80;
            rv = ($urandom_range(99) < rate_v);
            rr = ($urandom_range(99) < rate_r);
            rf = ($urandom_range(199) == 0);
            rd = 8'($urandom);
            flush_c = rf;
            applyStimulus(2, rv, rd, rr);
            #1;
            bypass    = (q.size() == 0);
            in_x      = rv && exp_ready_c;
            exp_valid = bypass ? in_x : 1'b1;
            exp_data  = bypass ? rd : q[0];
            checkOutput("rnd_ready", if_c.i_ready_o, exp_ready_c);
            checkOutput("rnd_level", level_c, q.size());
            checkOutput("rnd_af", almost_full_c, (q.size() >= 6) ? 1 : 0);
            checkOutput("rnd_valid", if_c.e_valid_o, exp_valid);
            if (exp_valid) checkOutput("rnd_data", if_c.e_data_o, exp_data);
            checkOutput("rnd_full_ready", (level_c == 4'd8) && if_c.i_ready_o, 1'b0);
            out_x = exp_valid && rr;
            if (out_x && !bypass) void'(q.pop_front());
            if (in_x && !(bypass && out_x)) q.push_back(rd);
            if (rf) q.delete();
            exp_ready_c = (q.size() < 8) && !rf;
        end
        @(negedge clk);
        flush_c = 1'b0;
        applyStimulus(2, 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
